// File: rtl/fft_pkg.sv
// Shared constants, FSM state type and CRC-8 helper for the FFT symbol serializer.
// The CRC helper is only used when SYM_CRC_EN is defined.
package fft_pkg;

  localparam int WORD_W         = 48;
  localparam int BYTES_PER_WORD = 6;
  localparam int BIN_CNT        = 24;
  localparam int LVL_W          = 2;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    CRC
  } state_t;

  // Folds one byte into a running CRC-8, MSB first, no reflection.
  function automatic logic [7:0] crc8Byte(input logic [7:0] crcIn, input logic [7:0] dataIn);
    logic [7:0] c;
    c = crcIn ^ dataIn;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/fft_sym_serializer_sym_fifo.sv
// First-word-fall-through FIFO holding whole FFT energy words ahead of the serializer.
module sym_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 48
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  r_wrPtr;
  logic [AW:0]  r_rdPtr;
  logic [W-1:0] r_mem [DEPTH];
  logic         w_wrEn;
  logic         w_rdEn;

  // A pop in the same cycle frees a slot, so a push into a full FIFO is still taken.
  assign w_wrEn = push && (!full || pop);
  assign w_rdEn = pop && !empty;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_wrEn) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_rdEn) r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (w_wrEn) r_mem[r_wrPtr[AW-1:0]] <= din;
  end

  assign dout  = r_mem[r_rdPtr[AW-1:0]];
  assign empty = (r_wrPtr == r_rdPtr);
  assign full  = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);

endmodule

// File: rtl/fft_sym_serializer.sv
// Buffers 48-bit FFT energy words and streams them LSB byte first over push/stop.
// Define SYM_CRC_EN to append a CRC-8 byte after the six data bytes of each frame.
module fft_sym_serializer
  import fft_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              PushIn,
  input  logic [WORD_W-1:0] DataIn,
  input  logic              StopIn,
  output logic              PushOut,
  output logic [7:0]        DataOut,
  output logic              FirstOut,
  output logic              Overflow,
  output logic [CNT_W-1:0]  FrameCnt
);

  localparam logic [2:0] LAST_IDX = 3'(BYTES_PER_WORD - 1);

  state_t             r_state;
  state_t             w_nextState;
  logic [2:0]         r_idx;
  logic [2:0]         w_nextIdx;
  logic [WORD_W-1:0]  r_shift;
  logic [WORD_W-1:0]  w_nextShift;
  logic               r_pushOut;
  logic               w_nextPush;
  logic [7:0]         r_dataOut;
  logic [7:0]         w_nextData;
  logic               r_first;
  logic               w_nextFirst;
  logic               r_overflow;
  logic [CNT_W-1:0]   r_frameCnt;
  logic [CNT_W-1:0]   w_nextCnt;
  logic               w_transfer;
  logic               w_frameDone;
  logic               w_load;
  logic               w_pop;
  logic [WORD_W-1:0]  w_fifoDout;
  logic               w_full;
  logic               w_empty;
`ifdef SYM_CRC_EN
  logic [7:0]         r_crc;
  logic [7:0]         w_nextCrc;
`endif

  sym_fifo #(
    .DEPTH (DEPTH),
    .W     (WORD_W)
  ) u_fifo (
    .Clk   (Clk),
    .Reset (Reset),
    .push  (PushIn),
    .pop   (w_pop),
    .din   (DataIn),
    .dout  (w_fifoDout),
    .full  (w_full),
    .empty (w_empty)
  );

  assign w_transfer = r_pushOut && !StopIn;

  // Next-state and next-output logic; a finished frame chains straight into the next word.
  always_comb begin
    w_nextState = r_state;
    w_nextIdx   = r_idx;
    w_nextShift = r_shift;
    w_nextPush  = r_pushOut;
    w_nextData  = r_dataOut;
    w_nextFirst = r_first;
    w_nextCnt   = r_frameCnt;
    w_frameDone = 1'b0;
    w_load      = 1'b0;
    w_pop       = 1'b0;
`ifdef SYM_CRC_EN
    w_nextCrc   = r_crc;
`endif

    case (r_state)
      IDLE: begin
        if (!w_empty) w_load = 1'b1;
      end
      SEND: begin
        if (w_transfer) begin
`ifdef SYM_CRC_EN
          w_nextCrc = crc8Byte(r_crc, r_dataOut);
`endif
          if (r_idx != LAST_IDX) begin
            w_nextIdx   = r_idx + 1'b1;
            w_nextShift = r_shift >> 8;
            w_nextData  = r_shift[15:8];
            w_nextFirst = 1'b0;
          end else begin
`ifdef SYM_CRC_EN
            w_nextState = CRC;
            w_nextData  = crc8Byte(r_crc, r_dataOut);
            w_nextFirst = 1'b0;
`else
            w_frameDone = 1'b1;
`endif
          end
        end
      end
      CRC: begin
        if (w_transfer) w_frameDone = 1'b1;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase

    if (w_frameDone) begin
      w_nextCnt = r_frameCnt + 1'b1;
      if (!w_empty) begin
        w_load = 1'b1;
      end else begin
        w_nextPush  = 1'b0;
        w_nextFirst = 1'b0;
        w_nextState = IDLE;
      end
    end

    if (w_load) begin
      w_pop       = 1'b1;
      w_nextShift = w_fifoDout;
      w_nextData  = w_fifoDout[7:0];
      w_nextPush  = 1'b1;
      w_nextFirst = 1'b1;
      w_nextIdx   = 3'd0;
      w_nextState = SEND;
`ifdef SYM_CRC_EN
      w_nextCrc   = 8'h00;
`endif
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_idx      <= 3'd0;
      r_shift    <= '0;
      r_pushOut  <= 1'b0;
      r_dataOut  <= 8'h00;
      r_first    <= 1'b0;
      r_overflow <= 1'b0;
      r_frameCnt <= '0;
    end else begin
      r_state    <= w_nextState;
      r_idx      <= w_nextIdx;
      r_shift    <= w_nextShift;
      r_pushOut  <= w_nextPush;
      r_dataOut  <= w_nextData;
      r_first    <= w_nextFirst;
      r_frameCnt <= w_nextCnt;
      if (PushIn && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

`ifdef SYM_CRC_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_crc <= 8'h00;
    else       r_crc <= w_nextCrc;
  end
`endif

  assign PushOut  = r_pushOut;
  assign DataOut  = r_dataOut;
  assign FirstOut = r_first;
  assign Overflow = r_overflow;
  assign FrameCnt = r_frameCnt;

endmodule

// File: tb/tb_fft_sym_serializer.sv
// Self-checking bench for fft_sym_serializer: directed scenarios plus random words,
// scored against a byte-queue model of the frame stream (SYM_CRC_EN adds the CRC byte).
module tb_fft_sym_serializer;

`ifdef SYM_CRC_EN
  localparam int FRAME_LEN = 7;
`else
  localparam int FRAME_LEN = 6;
`endif

  logic        Clk = 1'b0;
  logic        Reset;
  logic        PushIn;
  logic [47:0] DataIn;
  logic        StopIn;
  logic        PushOut;
  logic [7:0]  DataOut;
  logic        FirstOut;
  logic        Overflow;
  logic [15:0] FrameCnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       first;
    logic [7:0] data;
  } expByte_t;

  expByte_t    expQ[$];
  int          expFrames = 0;
  logic [47:0] words[6];

  fft_sym_serializer #(
    .DEPTH (4),
    .CNT_W (16)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .PushIn   (PushIn),
    .DataIn   (DataIn),
    .StopIn   (StopIn),
    .PushOut  (PushOut),
    .DataOut  (DataOut),
    .FirstOut (FirstOut),
    .Overflow (Overflow),
    .FrameCnt (FrameCnt)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit-serial CRC-8 over the frame bytes in transmission order.
  function automatic logic [7:0] crcModel(input logic [47:0] w);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int n = 0; n < 6; n++) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[7] ^ w[8*n+b];
        c  = {c[6:0], 1'b0};
        if (fb) c = c ^ 8'h07;
      end
    end
    return c;
  endfunction

  task automatic addWord(input logic [47:0] w);
    expByte_t e;
    for (int n = 0; n < 6; n++) begin
      e.first = (n == 0);
      e.data  = w[8*n +: 8];
      expQ.push_back(e);
    end
`ifdef SYM_CRC_EN
    e.first = 1'b0;
    e.data  = crcModel(w);
    expQ.push_back(e);
`endif
    expFrames++;
  endtask

  function automatic logic [47:0] randWord();
    return {16'($urandom()), $urandom()};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [47:0] w, input bit accepted);
    PushIn = 1'b1;
    DataIn = w;
    if (accepted) addWord(w);
    tick();
    PushIn = 1'b0;
  endtask

  task automatic applyReset();
    Reset = 1'b1;
    expQ.delete();
    expFrames = 0;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic waitDrain(input string tag);
    int n;
    n = 0;
    while ((expQ.size() != 0 || PushOut) && n < 400) begin
      tick();
      n++;
    end
    checkOutput({tag, " drain"}, 64'(n < 400), 64'd1);
  endtask

  task automatic waitByte(input logic [7:0] b, input string tag);
    int n;
    n = 0;
    while (!(PushOut && DataOut == b) && n < 50) begin
      tick();
      n++;
    end
    checkOutput({tag, " reach byte"}, 64'(n < 50), 64'd1);
  endtask

  // Scoreboard: every accepted byte must match the model; stalled outputs must hold.
  logic       prevValid = 1'b0;
  logic       prevStop;
  logic       prevPush;
  logic       prevFirst;
  logic [7:0] prevData;
  expByte_t   exb;

  always @(negedge Clk) begin
    if (Reset) begin
      prevValid <= 1'b0;
    end else begin
      if (prevValid && prevStop && prevPush) begin
        checkOutput("hold PushOut", 64'(PushOut), 64'd1);
        checkOutput("hold DataOut", 64'(DataOut), 64'(prevData));
        checkOutput("hold FirstOut", 64'(FirstOut), 64'(prevFirst));
      end
      if (PushOut && !StopIn) begin
        checkOutput("byte expected", 64'(expQ.size() != 0), 64'd1);
        if (expQ.size() != 0) begin
          exb = expQ.pop_front();
          checkOutput("stream DataOut", 64'(DataOut), 64'(exb.data));
          checkOutput("stream FirstOut", 64'(FirstOut), 64'(exb.first));
        end
      end
      prevValid <= 1'b1;
      prevStop  <= StopIn;
      prevPush  <= PushOut;
      prevFirst <= FirstOut;
      prevData  <= DataOut;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [47:0] w;
    logic [47:0] w2;

    Reset  = 1'b1;
    PushIn = 1'b0;
    StopIn = 1'b0;
    DataIn = '0;
    tick();
    tick();
    checkOutput("reset PushOut", 64'(PushOut), 64'd0);
    checkOutput("reset DataOut", 64'(DataOut), 64'd0);
    checkOutput("reset FirstOut", 64'(FirstOut), 64'd0);
    checkOutput("reset Overflow", 64'(Overflow), 64'd0);
    checkOutput("reset FrameCnt", 64'(FrameCnt), 64'd0);
    Reset = 1'b0;
    tick();

    $display("[TB] single word with latency check");
    applyStimulus(48'hA5A5_1234_5678, 1'b1);
    checkOutput("latency c+1 PushOut", 64'(PushOut), 64'd0);
    tick();
    checkOutput("latency c+2 PushOut", 64'(PushOut), 64'd1);
    checkOutput("first byte", 64'(DataOut), 64'h78);
    checkOutput("first FirstOut", 64'(FirstOut), 64'd1);
    for (int i = 1; i < FRAME_LEN; i++) begin
      tick();
      checkOutput("single burst PushOut", 64'(PushOut), 64'd1);
      checkOutput("single FirstOut low", 64'(FirstOut), 64'd0);
    end
    tick();
    checkOutput("single end PushOut", 64'(PushOut), 64'd0);
    checkOutput("single FrameCnt", 64'(FrameCnt), 64'd1);

    $display("[TB] backpressure on byte 2");
    applyStimulus(48'hA5A5_1234_5678, 1'b1);
    waitByte(8'h34, "backpressure");
    StopIn = 1'b1;
    tick();
    tick();
    tick();
    StopIn = 1'b0;
    checkOutput("stall still 0x34", 64'(DataOut), 64'h34);
    tick();
    checkOutput("after stall 0x12", 64'(DataOut), 64'h12);
    waitDrain("backpressure");
    checkOutput("backpressure FrameCnt", 64'(FrameCnt), 64'd2);

    $display("[TB] overflow with output stalled");
    applyReset();
    StopIn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      words[i] = randWord();
      if (i == 5) checkOutput("no overflow before 6th", 64'(Overflow), 64'd0);
      applyStimulus(words[i], i < 5);
    end
    tick();
    checkOutput("overflow set", 64'(Overflow), 64'd1);
    checkOutput("stalled PushOut", 64'(PushOut), 64'd1);
    checkOutput("stalled head byte", 64'(DataOut), 64'(words[0][7:0]));
    StopIn = 1'b0;
    waitDrain("overflow");
    checkOutput("overflow FrameCnt", 64'(FrameCnt), 64'(expFrames));
    checkOutput("overflow FrameCnt five", 64'(FrameCnt), 64'd5);
    checkOutput("overflow sticky", 64'(Overflow), 64'd1);

    $display("[TB] back-to-back words");
    applyReset();
    w  = randWord();
    w2 = randWord();
    PushIn = 1'b1;
    DataIn = w;
    addWord(w);
    tick();
    DataIn = w2;
    addWord(w2);
    tick();
    PushIn = 1'b0;
    for (int i = 0; i < 2 * FRAME_LEN; i++) begin
      checkOutput("no bubble PushOut", 64'(PushOut), 64'd1);
      tick();
    end
    checkOutput("b2b end PushOut", 64'(PushOut), 64'd0);
    checkOutput("b2b FrameCnt", 64'(FrameCnt), 64'd2);

    $display("[TB] reset during byte 3");
    applyStimulus(48'h6655_4433_2211, 1'b1);
    waitByte(8'h44, "mid-frame");
    Reset = 1'b1;
    #1;
    checkOutput("midreset PushOut", 64'(PushOut), 64'd0);
    checkOutput("midreset DataOut", 64'(DataOut), 64'd0);
    checkOutput("midreset FirstOut", 64'(FirstOut), 64'd0);
    checkOutput("midreset Overflow", 64'(Overflow), 64'd0);
    checkOutput("midreset FrameCnt", 64'(FrameCnt), 64'd0);
    expQ.delete();
    expFrames = 0;
    tick();
    Reset = 1'b0;
    tick();
    tick();
    checkOutput("fifo empty after reset", 64'(PushOut), 64'd0);
    applyStimulus(randWord(), 1'b1);
    waitDrain("after reset");
    checkOutput("after reset FrameCnt", 64'(FrameCnt), 64'd1);

    $display("[TB] random words with random backpressure");
    applyReset();
    for (int i = 0; i < 8; i++) begin
      w = (i == 0) ? 48'h0 : randWord();
      StopIn = ($urandom_range(0, 9) < 3);
      applyStimulus(w, 1'b1);
      for (int g = 0; g < int'($urandom_range(20, 30)); g++) begin
        StopIn = ($urandom_range(0, 9) < 3);
        tick();
      end
    end
    StopIn = 1'b0;
    waitDrain("random");
    checkOutput("random FrameCnt", 64'(FrameCnt), 64'(expFrames));
    checkOutput("random no overflow", 64'(Overflow), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
